// File: rtl/sap_control_sequencer_if.sv
// Control-word bundle between the SAP sequencer and the datapath it steers.
// The master side (sequencer) consumes run/opcode and drives every enable.
interface sap_control_sequencer_if;
   logic       input_run;
   logic [3:0] input_opcode;
   logic       output_pc_out;
   logic       output_pc_inc;
   logic       output_mar_load;
   logic       output_ram_out;
   logic       output_ir_load;
   logic       output_ir_out;
   logic       output_a_load;
   logic       output_a_out;
   logic       output_b_load;
   logic       output_sum_out;
   logic       output_sub;
   logic       output_out_load;
   logic [2:0] output_tstate;
   logic       output_halted;

   modport master (
      input  input_run, input_opcode,
      output output_pc_out, output_pc_inc, output_mar_load, output_ram_out, output_ir_load,
             output_ir_out, output_a_load, output_a_out, output_b_load, output_sum_out,
             output_sub, output_out_load, output_tstate, output_halted
   );

   modport slave (
      output input_run, input_opcode,
      input  output_pc_out, output_pc_inc, output_mar_load, output_ram_out, output_ir_load,
             output_ir_out, output_a_load, output_a_out, output_b_load, output_sum_out,
             output_sub, output_out_load, output_tstate, output_halted
   );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-1 style T-state sequencer and instruction decoder. The state register is the only
// storage; the control word is a zero-latency decode of the current state and opcode.
module sap_control_sequencer #(
   parameter bit EARLY_END = 1'b0
) (
   input logic                     clock,
   input logic                     input_clear_n,
   sap_control_sequencer_if.master bus
);

   localparam logic [3:0] OPC_LDA = 4'b0000;
   localparam logic [3:0] OPC_ADD = 4'b0001;
   localparam logic [3:0] OPC_SUB = 4'b0010;
   localparam logic [3:0] OPC_OUT = 4'b1110;
   localparam logic [3:0] OPC_HLT = 4'b1111;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StT1   = 3'd1,
      StT2   = 3'd2,
      StT3   = 3'd3,
      StT4   = 3'd4,
      StT5   = 3'd5,
      StT6   = 3'd6,
      StHalt = 3'd7
   } state_e;

   state_e state_q, state_d, boundary;
   logic   is_nop;

   assign is_nop = !(bus.input_opcode inside {OPC_LDA, OPC_ADD, OPC_SUB, OPC_OUT, OPC_HLT});
   assign boundary = bus.input_run ? StT1 : StIdle;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = bus.input_run ? StT1 : StIdle;
         StT1:    state_d = StT2;
         StT2:    state_d = StT3;
         StT3:    state_d = (EARLY_END && is_nop) ? boundary : StT4;
         StT4: begin
            if (bus.input_opcode == OPC_HLT)                 state_d = StHalt;
            else if (EARLY_END && bus.input_opcode == OPC_OUT) state_d = boundary;
            else                                               state_d = StT5;
         end
         StT5:    state_d = (EARLY_END && bus.input_opcode == OPC_LDA) ? boundary : StT6;
         StT6:    state_d = boundary;
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge input_clear_n) begin
      if (!input_clear_n) state_q <= StIdle;
      else                state_q <= state_d;
   end

   always_comb begin
      bus.output_pc_out   = 1'b0;
      bus.output_pc_inc   = 1'b0;
      bus.output_mar_load = 1'b0;
      bus.output_ram_out  = 1'b0;
      bus.output_ir_load  = 1'b0;
      bus.output_ir_out   = 1'b0;
      bus.output_a_load   = 1'b0;
      bus.output_a_out    = 1'b0;
      bus.output_b_load   = 1'b0;
      bus.output_sum_out  = 1'b0;
      bus.output_sub      = 1'b0;
      bus.output_out_load = 1'b0;
      unique case (state_q)
         StT1: begin
            bus.output_pc_out   = 1'b1;
            bus.output_mar_load = 1'b1;
         end
         StT2: bus.output_pc_inc = 1'b1;
         StT3: begin
            bus.output_ram_out = 1'b1;
            bus.output_ir_load = 1'b1;
         end
         StT4: begin
            if (bus.input_opcode inside {OPC_LDA, OPC_ADD, OPC_SUB}) begin
               bus.output_ir_out   = 1'b1;
               bus.output_mar_load = 1'b1;
            end else if (bus.input_opcode == OPC_OUT) begin
               bus.output_a_out    = 1'b1;
               bus.output_out_load = 1'b1;
            end
         end
         StT5: begin
            if (bus.input_opcode inside {OPC_LDA, OPC_ADD, OPC_SUB}) begin
               bus.output_ram_out = 1'b1;
               bus.output_a_load  = (bus.input_opcode == OPC_LDA);
               bus.output_b_load  = (bus.input_opcode != OPC_LDA);
               bus.output_sub     = (bus.input_opcode == OPC_SUB);
            end
         end
         StT6: begin
            if (bus.input_opcode inside {OPC_ADD, OPC_SUB}) begin
               bus.output_sum_out = 1'b1;
               bus.output_a_load  = 1'b1;
               bus.output_sub     = (bus.input_opcode == OPC_SUB);
            end
         end
         default: ;
      endcase
   end

   assign bus.output_tstate = state_q;
   assign bus.output_halted = (state_q == StHalt);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for the SAP sequencer: one default instance and one with early end.
module tb_sap_control_sequencer;

   // Control word packing: {pc_out,pc_inc,mar_load,ram_out,ir_load,ir_out,
   //                        a_load,a_out,b_load,sum_out,sub,out_load}
   localparam logic [11:0] PC_OUT   = 12'h800;
   localparam logic [11:0] PC_INC   = 12'h400;
   localparam logic [11:0] MAR_LOAD = 12'h200;
   localparam logic [11:0] RAM_OUT  = 12'h100;
   localparam logic [11:0] IR_LOAD  = 12'h080;
   localparam logic [11:0] IR_OUT   = 12'h040;
   localparam logic [11:0] A_LOAD   = 12'h020;
   localparam logic [11:0] A_OUT    = 12'h010;
   localparam logic [11:0] B_LOAD   = 12'h008;
   localparam logic [11:0] SUM_OUT  = 12'h004;
   localparam logic [11:0] SUB      = 12'h002;
   localparam logic [11:0] OUT_LOAD = 12'h001;

   localparam logic [3:0] LDA = 4'b0000;
   localparam logic [3:0] ADD = 4'b0001;
   localparam logic [3:0] SBT = 4'b0010;
   localparam logic [3:0] OUT = 4'b1110;
   localparam logic [3:0] HLT = 4'b1111;
   localparam logic [3:0] NOP = 4'b0101;

   logic clock = 1'b0;
   logic clear_n = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;

   sap_control_sequencer_if bus0 ();
   sap_control_sequencer_if bus1 ();

   sap_control_sequencer #(.EARLY_END(1'b0)) dut0 (
      .clock(clock), .input_clear_n(clear_n), .bus(bus0.master)
   );
   sap_control_sequencer #(.EARLY_END(1'b1)) dut1 (
      .clock(clock), .input_clear_n(clear_n), .bus(bus1.master)
   );

   logic [11:0] cw0, cw1;
   logic [3:0]  drv0, drv1;
   assign cw0 = {bus0.output_pc_out, bus0.output_pc_inc, bus0.output_mar_load,
                 bus0.output_ram_out, bus0.output_ir_load, bus0.output_ir_out,
                 bus0.output_a_load, bus0.output_a_out, bus0.output_b_load,
                 bus0.output_sum_out, bus0.output_sub, bus0.output_out_load};
   assign cw1 = {bus1.output_pc_out, bus1.output_pc_inc, bus1.output_mar_load,
                 bus1.output_ram_out, bus1.output_ir_load, bus1.output_ir_out,
                 bus1.output_a_load, bus1.output_a_out, bus1.output_b_load,
                 bus1.output_sum_out, bus1.output_sub, bus1.output_out_load};
   assign drv0 = {bus0.output_pc_out, bus0.output_ram_out, bus0.output_ir_out,
                  bus0.output_a_out} | {3'b000, bus0.output_sum_out};
   assign drv1 = {bus1.output_pc_out, bus1.output_ram_out, bus1.output_ir_out,
                  bus1.output_a_out} | {3'b000, bus1.output_sum_out};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Bus drivers must be one-hot-or-zero on every cycle, for both instances.
   always @(negedge clock) begin
      n_checks += 2;
      assert ($onehot0({bus0.output_pc_out, bus0.output_ram_out, bus0.output_ir_out,
                        bus0.output_a_out, bus0.output_sum_out}))
      else begin
         n_fail++;
         $error("FAIL onehot0: observed drivers %b expected at most one", drv0);
      end
      assert ($onehot0({bus1.output_pc_out, bus1.output_ram_out, bus1.output_ir_out,
                        bus1.output_a_out, bus1.output_sum_out}))
      else begin
         n_fail++;
         $error("FAIL onehot1: observed drivers %b expected at most one", drv1);
      end
   end

   initial begin
      bus0.input_run = 1'b0; bus0.input_opcode = LDA;
      bus1.input_run = 1'b0; bus1.input_opcode = LDA;

      // 1. reset and idle
      #1 clear_n = 1'b0;
      #1;
      check("rst_cw", 16'(cw0), 16'h0);
      check("rst_ts", 16'(bus0.output_tstate), 16'd0);
      tick(); tick();
      check("rst_hold_cw", 16'(cw0), 16'h0);
      check("rst_hold_halt", 16'(bus0.output_halted), 16'd0);
      clear_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_ts", 16'(bus0.output_tstate), 16'd0);
      end

      // 2. LDA
      bus0.input_run = 1'b1; bus0.input_opcode = LDA;
      tick(); check("lda_t1_ts", 16'(bus0.output_tstate), 16'd1);
      check("lda_t1", 16'(cw0), 16'(PC_OUT | MAR_LOAD));
      tick(); check("lda_t2", 16'(cw0), 16'(PC_INC));
      tick(); check("lda_t3", 16'(cw0), 16'(RAM_OUT | IR_LOAD));
      tick(); check("lda_t4", 16'(cw0), 16'(IR_OUT | MAR_LOAD));
      tick(); check("lda_t5_ts", 16'(bus0.output_tstate), 16'd5);
      check("lda_t5", 16'(cw0), 16'(RAM_OUT | A_LOAD));
      tick(); check("lda_t6_ts", 16'(bus0.output_tstate), 16'd6);
      check("lda_t6", 16'(cw0), 16'h0);
      tick(); check("lda_wrap", 16'(bus0.output_tstate), 16'd1);

      // 3. SUB then ADD
      bus0.input_opcode = SBT;
      tick(); tick(); tick();
      check("sub_t4", 16'(cw0), 16'(IR_OUT | MAR_LOAD));
      tick(); check("sub_t5", 16'(cw0), 16'(RAM_OUT | B_LOAD | SUB));
      tick(); check("sub_t6", 16'(cw0), 16'(SUM_OUT | A_LOAD | SUB));
      tick(); check("sub_wrap", 16'(bus0.output_tstate), 16'd1);
      bus0.input_opcode = ADD;
      tick(); tick(); tick();
      check("add_t4", 16'(cw0), 16'(IR_OUT | MAR_LOAD));
      tick(); check("add_t5", 16'(cw0), 16'(RAM_OUT | B_LOAD));
      tick(); check("add_t6", 16'(cw0), 16'(SUM_OUT | A_LOAD));
      tick(); check("add_wrap", 16'(bus0.output_tstate), 16'd1);

      // 4. HLT
      bus0.input_opcode = HLT;
      tick(); tick(); tick();
      check("hlt_t4_ts", 16'(bus0.output_tstate), 16'd4);
      check("hlt_t4", 16'(cw0), 16'h0);
      tick(); check("hlt_ts", 16'(bus0.output_tstate), 16'd7);
      check("hlt_flag", 16'(bus0.output_halted), 16'd1);
      check("hlt_cw", 16'(cw0), 16'h0);
      for (int i = 0; i < 10; i++) begin
         bus0.input_run = ~bus0.input_run;
         tick();
         check("hlt_hold", 16'(bus0.output_tstate), 16'd7);
      end
      bus0.input_run = 1'b1;
      clear_n = 1'b0;
      #1;
      check("hlt_clr_ts", 16'(bus0.output_tstate), 16'd0);
      check("hlt_clr_flag", 16'(bus0.output_halted), 16'd0);
      clear_n = 1'b1;

      // 5. run dropped mid-instruction, then reset during T5
      bus0.input_opcode = ADD;
      tick(); check("drop_t1", 16'(bus0.output_tstate), 16'd1);
      tick(); tick();
      bus0.input_run = 1'b0;
      tick(); tick(); tick();
      check("drop_t6", 16'(bus0.output_tstate), 16'd6);
      tick(); check("drop_idle", 16'(bus0.output_tstate), 16'd0);
      tick(); check("drop_stay", 16'(bus0.output_tstate), 16'd0);
      bus0.input_run = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("clr_t5_ts", 16'(bus0.output_tstate), 16'd5);
      bus0.input_run = 1'b0;
      clear_n = 1'b0;
      #1;
      check("clr_t5_ts0", 16'(bus0.output_tstate), 16'd0);
      check("clr_t5_cw", 16'(cw0), 16'h0);
      #2 clear_n = 1'b1;
      tick();
      check("clr_after_ts", 16'(bus0.output_tstate), 16'd0);
      check("clr_after_aload", 16'(bus0.output_a_load), 16'd0);

      // 6. early end: OUT, LDA, NOP
      bus1.input_run = 1'b1; bus1.input_opcode = OUT;
      tick(); check("ee_out_t1", 16'(bus1.output_tstate), 16'd1);
      tick(); check("ee_out_t2", 16'(bus1.output_tstate), 16'd2);
      tick(); check("ee_out_t3", 16'(bus1.output_tstate), 16'd3);
      tick(); check("ee_out_t4", 16'(bus1.output_tstate), 16'd4);
      check("ee_out_cw", 16'(cw1), 16'(A_OUT | OUT_LOAD));
      tick(); check("ee_lda_t1", 16'(bus1.output_tstate), 16'd1);
      bus1.input_opcode = LDA;
      tick(); check("ee_lda_t2", 16'(bus1.output_tstate), 16'd2);
      tick(); check("ee_lda_t3", 16'(bus1.output_tstate), 16'd3);
      tick(); check("ee_lda_t4", 16'(bus1.output_tstate), 16'd4);
      tick(); check("ee_lda_t5", 16'(bus1.output_tstate), 16'd5);
      check("ee_lda_cw", 16'(cw1), 16'(RAM_OUT | A_LOAD));
      tick(); check("ee_nop_t1", 16'(bus1.output_tstate), 16'd1);
      bus1.input_opcode = NOP;
      tick(); tick();
      check("ee_nop_t3", 16'(bus1.output_tstate), 16'd3);
      bus1.input_run = 1'b0;
      tick(); check("ee_nop_idle", 16'(bus1.output_tstate), 16'd0);
      check("ee_nop_cw", 16'(cw1), 16'h0);
      check("ee_dut0_idle", 16'(bus0.output_tstate), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
